// File: rtl/imem_access_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters
// (fetch and boot loader) and the single-port memory array.
interface imem_access_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_AW    = 18
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;
  logic                  f_misalign;
  logic                  l_req;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic                  l_done;
  logic                  l_gnt;
  logic                  mem_en;
  logic                  mem_we;
  logic [WORD_AW-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, l_done, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_misalign, l_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, l_done, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_misalign, l_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Shares the single-port instruction memory between fetch and the boot loader:
// loader-only BOOT phase, then round-robin RUN phase with a 1-cycle fetch response.
module imem_access_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_AW    = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_access_arbiter_if.slave bus,
  output logic                 run,
  output logic [WORD_AW:0]     load_count
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  last_loader_r;
  logic                  last_loader_nxt_s;
  logic                  f_gnt_s;
  logic                  l_gnt_s;
  logic                  f_misal_s;
  logic                  rsp_pend_r;
  logic                  rsp_mis_r;
  logic [DATA_WIDTH-1:0] rdata_hold_r;
  logic [DATA_WIDTH-1:0] f_rdata_s;
  logic [WORD_AW:0]      load_count_r;
  logic                  unused_s;

  assign f_misal_s = (bus.f_addr[1:0] != 2'b00);
  // Upper address bits wrap away; loader low bits are ignored (word-only writes).
  assign unused_s  = ^{bus.f_addr[ADDR_WIDTH-1:WORD_AW+2],
                       bus.l_addr[ADDR_WIDTH-1:WORD_AW+2], bus.l_addr[1:0]};

  // Phase sequencing and round-robin grant selection.
  always_comb begin
    f_gnt_s           = 1'b0;
    l_gnt_s           = 1'b0;
    state_nxt_s       = state_r;
    last_loader_nxt_s = last_loader_r;
    case (state_r)
      ST_BOOT: begin
        l_gnt_s = bus.l_req;
        if (bus.l_done) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_BOOT;
        end
      end
      ST_RUN: begin
        if (bus.f_req && bus.l_req) begin
          if (last_loader_r) begin
            f_gnt_s = 1'b1;
          end else begin
            l_gnt_s = 1'b1;
          end
          last_loader_nxt_s = ~last_loader_r;
        end else begin
          f_gnt_s = bus.f_req;
          l_gnt_s = bus.l_req;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // Memory port drive for the granted requester; a misaligned fetch is granted but not issued.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {WORD_AW{1'b0}};
    bus.mem_wdata = {DATA_WIDTH{1'b0}};
    if (l_gnt_s) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.l_addr[WORD_AW+1:2];
      bus.mem_wdata = bus.l_wdata;
    end else if (f_gnt_s && !f_misal_s) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.f_addr[WORD_AW+1:2];
    end else begin
      bus.mem_en = 1'b0;
    end
  end

  // Phase and arbitration-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_BOOT;
      last_loader_r <= 1'b1;
    end else begin
      state_r       <= state_nxt_s;
      last_loader_r <= last_loader_nxt_s;
    end
  end

  // Saturating count of accepted loader writes; MSB set means 2^WORD_AW reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count_r <= {(WORD_AW+1){1'b0}};
    end else if (l_gnt_s && !load_count_r[WORD_AW]) begin
      load_count_r <= load_count_r + {{WORD_AW{1'b0}}, 1'b1};
    end
  end

  // Response tracking: rdata and misalign hold their last shown values between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_r   <= 1'b0;
      rsp_mis_r    <= 1'b0;
      rdata_hold_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp_pend_r <= f_gnt_s;
      if (f_gnt_s) begin
        rsp_mis_r <= f_misal_s;
      end
      if (rsp_pend_r) begin
        rdata_hold_r <= f_rdata_s;
      end
    end
  end

  // Memory read data lands one cycle after issue, so it is forwarded rather than re-registered.
  always_comb begin
    f_rdata_s = rdata_hold_r;
    if (rsp_pend_r) begin
      if (rsp_mis_r) begin
        f_rdata_s = {DATA_WIDTH{1'b0}};
      end else begin
        f_rdata_s = bus.mem_rdata;
      end
    end else begin
      f_rdata_s = rdata_hold_r;
    end
  end

  assign bus.f_gnt      = f_gnt_s;
  assign bus.l_gnt      = l_gnt_s;
  assign bus.f_rvalid   = rsp_pend_r;
  assign bus.f_rdata    = f_rdata_s;
  assign bus.f_misalign = rsp_mis_r;
  assign run            = (state_r == ST_RUN);
  assign load_count     = load_count_r;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the arbiter.
module tb_imem_access_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WAW = 18;

  logic           clk = 1'b0;
  logic           rst;
  logic           run;
  logic [WAW:0]   load_count;

  imem_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_AW(WAW)) bus ();

  imem_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_AW(WAW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .run        (run),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory array: write-then-read, registered read data.
  logic [31:0] tb_mem [int unsigned];
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) begin
        tb_mem[32'(bus.mem_addr)] = bus.mem_wdata;
      end else begin
        bus.mem_rdata <= tb_mem.exists(32'(bus.mem_addr)) ? tb_mem[32'(bus.mem_addr)] : 32'h0;
      end
    end
  end

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % (32'd1 << WAW);
  endfunction

  // Reference model state.
  bit          m_run, m_last_l, m_pv, m_pmis, m_omis;
  int unsigned m_count;
  logic [31:0] m_pdata, m_odata;
  logic [31:0] m_img [int unsigned];
  bit          chk_en = 1'b0;
  bit          s_fg, s_lg;

  always @(negedge clk) begin : model_cmp
    bit          efg, elg, fmis, een, ewe;
    int unsigned eaddr;
    logic [31:0] ewd;
    efg = 1'b0;
    elg = 1'b0;
    if (!m_run) begin
      elg = bus.l_req;
    end else if (bus.f_req && bus.l_req) begin
      efg = m_last_l;
      elg = !m_last_l;
    end else begin
      efg = bus.f_req;
      elg = bus.l_req;
    end
    fmis  = (bus.f_addr % 4) != 0;
    een   = 1'b0; ewe = 1'b0; eaddr = 0; ewd = 32'h0;
    if (elg) begin
      een = 1'b1; ewe = 1'b1; eaddr = widx(bus.l_addr); ewd = bus.l_wdata;
    end else if (efg && !fmis) begin
      een = 1'b1; eaddr = widx(bus.f_addr);
    end
    if (chk_en) begin
      chk("f_gnt",      64'(bus.f_gnt),      64'(efg));
      chk("l_gnt",      64'(bus.l_gnt),      64'(elg));
      chk("mem_en",     64'(bus.mem_en),     64'(een));
      chk("mem_we",     64'(bus.mem_we),     64'(ewe));
      chk("mem_addr",   64'(bus.mem_addr),   64'(eaddr));
      chk("mem_wdata",  64'(bus.mem_wdata),  64'(ewd));
      chk("f_rvalid",   64'(bus.f_rvalid),   64'(m_pv));
      chk("f_rdata",    64'(bus.f_rdata),    64'(m_pv ? m_pdata : m_odata));
      chk("f_misalign", 64'(bus.f_misalign), 64'(m_pv ? m_pmis : m_omis));
      chk("run",        64'(run),            64'(m_run));
      chk("load_count", 64'(load_count),     64'(m_count));
    end
    s_fg = bus.f_gnt;
    s_lg = bus.l_gnt;
    if (elg) m_img[widx(bus.l_addr)] = bus.l_wdata;
    if (rst) begin
      m_run = 1'b0; m_last_l = 1'b1; m_count = 0; m_pv = 1'b0;
      m_pmis = 1'b0; m_omis = 1'b0; m_pdata = 32'h0; m_odata = 32'h0;
    end else begin
      if (m_pv) begin
        m_odata = m_pdata;
        m_omis  = m_pmis;
      end
      if (efg) begin
        m_pmis  = fmis;
        m_pdata = fmis ? 32'h0 : (m_img.exists(widx(bus.f_addr)) ? m_img[widx(bus.f_addr)] : 32'h0);
      end
      if (m_run && bus.f_req && bus.l_req) m_last_l = elg;
      m_pv = efg;
      if (elg && m_count < (32'd1 << WAW)) m_count++;
      if (!m_run && bus.l_done) m_run = 1'b1;
    end
  end

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] raddr(input bit allow_mis);
    logic [31:0] a;
    a       = $urandom;
    a[19:6] = 14'h0;
    if (!allow_mis || $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = 32'h0; bus.l_req = 1'b0;
    bus.l_addr = 32'h0; bus.l_wdata = 32'h0; bus.l_done = 1'b0;
    repeat (2) next();
    rst = 1'b0;
    chk_en = 1'b1;

    // Fetch stalled throughout BOOT.
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      nedge();
      chk("boot_fgnt", 64'(bus.f_gnt), 64'd0);
      chk("boot_rvalid", 64'(bus.f_rvalid), 64'd0);
      chk("boot_run", 64'(run), 64'd0);
      next();
    end
    bus.f_req = 1'b0;

    // Load two words, l_done together with the second write.
    bus.l_req = 1'b1; bus.l_addr = 32'h0; bus.l_wdata = 32'h00000013;
    nedge(); chk("load0_gnt", 64'(bus.l_gnt), 64'd1); next();
    bus.l_addr = 32'h4; bus.l_wdata = 32'h00A00093; bus.l_done = 1'b1;
    nedge(); chk("load1_gnt", 64'(bus.l_gnt), 64'd1); next();
    bus.l_req = 1'b0; bus.l_done = 1'b0;
    nedge();
    chk("run_after_done", 64'(run), 64'd1);
    chk("load_count2", 64'(load_count), 64'd2);

    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    nedge(); chk("fetch0_gnt", 64'(bus.f_gnt), 64'd1); next();
    bus.f_addr = 32'h4;
    nedge();
    chk("fetch0_rvalid", 64'(bus.f_rvalid), 64'd1);
    chk("fetch0_rdata", 64'(bus.f_rdata), 64'h00000013);
    next();
    bus.f_req = 1'b0;
    nedge();
    chk("fetch1_rvalid", 64'(bus.f_rvalid), 64'd1);
    chk("fetch1_rdata", 64'(bus.f_rdata), 64'h00A00093);
    next();

    // Both requesting: fetch wins the first tie, then strict alternation.
    bus.f_req = 1'b1; bus.f_addr = 32'h8;
    bus.l_req = 1'b1; bus.l_addr = 32'h100; bus.l_wdata = 32'hCAFE0001;
    for (int i = 0; i < 6; i++) begin
      nedge();
      chk("alt_fgnt", 64'(bus.f_gnt), 64'((i % 2) == 0));
      chk("alt_we", 64'(bus.mem_we), 64'((i % 2) == 1));
      next();
    end
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    next();

    // Misaligned fetch is granted without a memory access.
    bus.f_req = 1'b1; bus.f_addr = 32'h6;
    nedge();
    chk("mis_gnt", 64'(bus.f_gnt), 64'd1);
    chk("mis_en", 64'(bus.mem_en), 64'd0);
    next();
    bus.f_req = 1'b0;
    nedge();
    chk("mis_rvalid", 64'(bus.f_rvalid), 64'd1);
    chk("mis_flag", 64'(bus.f_misalign), 64'd1);
    chk("mis_rdata", 64'(bus.f_rdata), 64'd0);
    next();

    // Address wrap on the loader side.
    bus.l_req = 1'b1; bus.l_addr = 32'h00100004; bus.l_wdata = 32'h12345678;
    nedge(); chk("wrap_addr", 64'(bus.mem_addr), 64'h1); next();
    bus.l_req = 1'b0;

    // Reset in the middle of a fetch stream.
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    next();
    bus.f_addr = 32'h4; rst = 1'b1;
    nedge(); chk("rst_cycle_gnt", 64'(bus.f_gnt), 64'd1); next();
    bus.f_addr = 32'h8; rst = 1'b0;
    nedge();
    chk("post_rst_rvalid", 64'(bus.f_rvalid), 64'd0);
    chk("post_rst_run", 64'(run), 64'd0);
    chk("post_rst_count", 64'(load_count), 64'd0);
    next();
    bus.f_req = 1'b0;

    // Randomized traffic, requests held until granted.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!(bus.f_req && !s_fg)) begin
        bus.f_req  = ($urandom_range(0, 2) != 0);
        bus.f_addr = raddr(1'b1);
      end
      if (!(bus.l_req && !s_lg)) begin
        bus.l_req   = ($urandom_range(0, 1) != 0);
        bus.l_addr  = $urandom;
        bus.l_addr[19:6] = 14'h0;
        bus.l_wdata = $urandom;
      end
      bus.l_done = ($urandom_range(0, 29) == 0);
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
